// File: rtl/qsys_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qsys_nios2_qsys_0_oci_dct_packer : packs 2-bit DCT trace codes into packets
// Revision 1.0
// ---------------------------------------------------------------------------
module qsys_nios2_qsys_0_oci_dct_packer #(
  parameter int FRAME_W = 2,
  parameter int DEPTH   = 15,
  parameter int COUNT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       trc_on,
  input  logic                       dct_valid,
  input  logic [FRAME_W-1:0]         dct_code,
  input  logic                       flush,
  output logic [FRAME_W*DEPTH-1:0]   dct_buffer,
  output logic [COUNT_W-1:0]         dct_count,
  output logic                       pkt_valid,
  output logic [FRAME_W*DEPTH-1:0]   pkt_data,
  output logic [COUNT_W-1:0]         pkt_count,
  input  logic                       pkt_ready,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int BUF_W = FRAME_W * DEPTH;

  logic flush_pend;
  logic trc_on_d;

  logic acc;
  logic slot_free;
  logic full;
  logic move;
  logic drop;
  logic flush_set;
  logic flush_clr;

  assign acc       = trc_on & dct_valid;
  assign slot_free = !pkt_valid | pkt_ready;
  assign full      = (dct_count == COUNT_W'(DEPTH));
  assign move      = slot_free & (full | (flush_pend & (dct_count != '0)));
  assign drop      = acc & full & !move;
  assign flush_set = flush | (trc_on_d & !trc_on);
  assign flush_clr = move | ((dct_count == '0) & !acc);

  // A code arriving in the move cycle restarts the buffer rather than being lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (move) begin
      if (acc) begin
        dct_buffer <= {{(BUF_W-FRAME_W){1'b0}}, dct_code};
        dct_count  <= COUNT_W'(1);
      end else begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end
    end else if (acc && !full) begin
      dct_buffer <= {dct_buffer[BUF_W-FRAME_W-1:0], dct_code};
      dct_count  <= dct_count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_count <= '0;
    end else if (move) begin
      pkt_valid <= 1'b1;
      pkt_data  <= dct_buffer;
      pkt_count <= dct_count;
    end else if (pkt_valid && pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

  // A new flush request outranks the clear so a code stored alongside it still gets emitted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
      trc_on_d   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      trc_on_d <= trc_on;
      if (flush_set)
        flush_pend <= 1'b1;
      else if (flush_clr)
        flush_pend <= 1'b0;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clear)
        overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire
